ram_seq_master: RTL and testbench

RAM_SEQ_MASTER -- requirements
Module: ram_seq_master

---
 rtl/ram_pkg.sv | 15 +
 rtl/ram_seq_master_if.sv | 51 +++++
 rtl/ram_seq_master.sv | 129 ++++++++++++
 tb/tb_ram_seq_master.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared defaults and FSM state encoding for the RAM burst sequencer.
package ram_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_CAPT,
        RD_OUT
    } state_t;

endpackage

// File: rtl/ram_seq_master_if.sv
// Command, write-beat, read-beat and RAM-side signals of the burst sequencer.
interface ram_seq_master_if
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;

    logic              wd_valid;
    logic              wd_ready;
    logic [DATA_W-1:0] wd_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;

    logic              done;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr_en;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Sequencer side
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wd_valid, wd_data,
        input  rd_ready,
        input  ram_rdata,
        output cmd_ready, wd_ready, rd_valid, rd_data, rd_last, done,
        output ram_addr, ram_wr_en, ram_wdata
    );

    // Environment side (command source, data producer/consumer, RAM)
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wd_valid, wd_data,
        output rd_ready,
        output ram_rdata,
        input  cmd_ready, wd_ready, rd_valid, rd_data, rd_last, done,
        input  ram_addr, ram_wr_en, ram_wdata
    );

endinterface

// File: rtl/ram_seq_master.sv
// Burst sequencer: turns write/read burst commands into single-port RAM cycles.
module ram_seq_master
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    ram_seq_master_if.master bus
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_count;
    logic              r_cmd_ready;
    logic              r_wd_ready;
    logic              r_rd_valid;
    logic              r_rd_last;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_done;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_wr_en;
    logic [DATA_W-1:0] r_ram_wdata;

    logic w_cmd_fire;
    logic w_wd_fire;
    logic w_rd_fire;
    logic w_last;

    assign w_cmd_fire = bus.cmd_valid & r_cmd_ready;
    assign w_wd_fire  = bus.wd_valid & r_wd_ready;
    assign w_rd_fire  = r_rd_valid & bus.rd_ready;
    assign w_last     = (r_count == r_len);

    // Burst FSM; the read address is registered on entry to RD_ISSUE so the
    // synchronous RAM returns data while the FSM sits in RD_CAPT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_len       <= '0;
            r_count     <= '0;
            r_cmd_ready <= 1'b1;
            r_wd_ready  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_rd_data   <= '0;
            r_done      <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wr_en <= 1'b0;
            r_ram_wdata <= '0;
        end else begin
            r_ram_wr_en <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cmd_fire) begin
                        r_base      <= bus.cmd_addr;
                        r_len       <= bus.cmd_len;
                        r_count     <= '0;
                        r_cmd_ready <= 1'b0;
                        if (bus.cmd_write) begin
                            r_wd_ready <= 1'b1;
                            r_state    <= WRITE;
                        end else begin
                            r_ram_addr <= bus.cmd_addr;
                            r_state    <= RD_ISSUE;
                        end
                    end
                end
                WRITE: begin
                    if (w_wd_fire) begin
                        r_ram_wr_en <= 1'b1;
                        r_ram_addr  <= r_base + r_count;
                        r_ram_wdata <= bus.wd_data;
                        if (w_last) begin
                            r_wd_ready  <= 1'b0;
                            r_cmd_ready <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_count <= r_count + ADDR_W'(1);
                        end
                    end
                end
                RD_ISSUE: begin
                    r_state <= RD_CAPT;
                end
                RD_CAPT: begin
                    r_rd_data  <= bus.ram_rdata;
                    r_rd_valid <= 1'b1;
                    r_rd_last  <= w_last;
                    r_state    <= RD_OUT;
                end
                RD_OUT: begin
                    if (w_rd_fire) begin
                        r_rd_valid <= 1'b0;
                        r_rd_last  <= 1'b0;
                        if (w_last) begin
                            r_cmd_ready <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_count    <= r_count + ADDR_W'(1);
                            r_ram_addr <= r_base + r_count + ADDR_W'(1);
                            r_state    <= RD_ISSUE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.wd_ready  = r_wd_ready;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_last   = r_rd_last;
    assign bus.done      = r_done;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wr_en = r_ram_wr_en;
    assign bus.ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_ram_seq_master.sv
// Bench for ram_seq_master: synchronous RAM model, expected-memory reference,
// directed burst scenarios followed by randomized bursts.
module tb_ram_seq_master;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] exp_mem [DEPTH];

    always #5 clk = ~clk;

    ram_seq_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_seq_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous RAM: read data one cycle after the address
    always @(posedge clk) begin
        if (bus.ram_wr_en) ram[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= ram[bus.ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input int addr, input int len, input logic noise);
        int n;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        check("cmd_ready_wait", 32'(n < 50), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = AW'(addr);
        bus.cmd_len   = AW'(len);
        bus.wd_valid  = noise;
        bus.wd_data   = 8'hEE;
        tick;
        bus.cmd_valid = 1'b0;
        bus.wd_valid  = 1'b0;
        check("cmd_taken", bus.cmd_ready, 0);
        check("cmd_no_wr", bus.ram_wr_en, 0);
        check("cmd_no_done", bus.done, 0);
    endtask

    task automatic do_write(input int addr, input int len, input int gap_pct,
                            input logic noise, input logic rnd, input logic [DW-1:0] d0);
        int i, cyc, pulses;
        logic hs;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        i = 0; cyc = 0; pulses = 0;
        send_cmd(1'b1, addr, len, noise);
        while (i <= len && cyc < 1000) begin
            bus.wd_valid  = ($urandom_range(99) >= 32'(gap_pct));
            bus.wd_data   = rnd ? DW'($urandom) : DW'(d0 + DW'(i));
            bus.cmd_valid = noise && (i < len) && ($urandom_range(1) == 1);
            bus.cmd_addr  = AW'($urandom);
            check("wd_ready_on", bus.wd_ready, 1);
            hs = bus.wd_valid && bus.wd_ready;
            ea = AW'(addr + i);
            ed = bus.wd_data;
            tick;
            cyc++;
            if (bus.ram_wr_en) pulses++;
            check("wr_en", bus.ram_wr_en, hs);
            check("wr_rd_valid", bus.rd_valid, 0);
            if (hs) begin
                check("wr_addr", bus.ram_addr, ea);
                check("wr_data", bus.ram_wdata, ed);
                check("wr_done", bus.done, 32'(i == len));
                exp_mem[ea] = ed;
                i++;
            end else begin
                check("wr_no_done", bus.done, 0);
            end
            check("wr_cmd_ready", bus.cmd_ready, 32'(i > len));
        end
        bus.wd_valid  = 1'b0;
        bus.cmd_valid = 1'b0;
        check("wr_beats", i, len + 1);
        check("wr_pulses", pulses, len + 1);
        check("wd_ready_off", bus.wd_ready, 0);
    endtask

    task automatic do_read(input int addr, input int len, input int bp_pct,
                           input logic noise, input int stall_beat);
        int beat, cyc, stall, last_fire;
        logic fire, pre_v;
        logic [DW-1:0] pre_d;
        logic [AW-1:0] pre_a;
        beat = 0; cyc = 0; stall = 0; last_fire = 0;
        send_cmd(1'b0, addr, len, noise);
        while (beat <= len && cyc < 2000) begin
            if (bus.rd_valid) begin
                check("rd_data", bus.rd_data, exp_mem[AW'(addr + beat)]);
                check("rd_last", bus.rd_last, 32'(beat == len));
            end
            if (bus.rd_valid && beat == stall_beat && stall < 5) begin
                bus.rd_ready = 1'b0;
                stall++;
            end else begin
                bus.rd_ready = ($urandom_range(99) >= 32'(bp_pct));
            end
            bus.wd_valid  = noise && ($urandom_range(1) == 1);
            bus.cmd_valid = noise && !bus.rd_valid && ($urandom_range(1) == 1);
            fire  = bus.rd_valid && bus.rd_ready;
            pre_v = bus.rd_valid;
            pre_d = bus.rd_data;
            pre_a = bus.ram_addr;
            tick;
            cyc++;
            check("rd_no_wr", bus.ram_wr_en, 0);
            check("rd_wd_ready", bus.wd_ready, 0);
            check("rd_done", bus.done, 32'(fire && beat == len));
            if (fire) begin
                if (bp_pct == 0 && stall_beat < 0)
                    check("rd_beat_gap", cyc - last_fire, 3);
                last_fire = cyc;
                beat++;
                check("rd_valid_drop", bus.rd_valid, 0);
            end else if (pre_v) begin
                check("rd_hold_v", bus.rd_valid, 1);
                check("rd_hold_d", bus.rd_data, pre_d);
                check("rd_hold_a", bus.ram_addr, pre_a);
            end
        end
        bus.rd_ready  = 1'b0;
        bus.wd_valid  = 1'b0;
        bus.cmd_valid = 1'b0;
        check("rd_beats", beat, len + 1);
        if (stall_beat >= 0) check("rd_stall", stall, 5);
        check("rd_cmd_ready", bus.cmd_ready, 1);
    endtask

    task automatic verify_ram(input int addr, input int len);
        tick;
        for (int i = 0; i <= len; i++)
            check("ram_word", ram[AW'(addr + i)], exp_mem[AW'(addr + i)]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wd_valid  = 1'b0;
        bus.wd_data   = '0;
        bus.rd_ready  = 1'b0;
        tick;
        tick;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_wd_ready", bus.wd_ready, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_done", bus.done, 0);
        check("rst_wr_en", bus.ram_wr_en, 0);
        check("rst_addr", bus.ram_addr, 0);
        check("rst_wdata", bus.ram_wdata, 0);
        reset = 1'b1;

        // Full-array burst straight after reset release; also fills the RAM
        do_write($urandom_range(DEPTH - 1), DEPTH - 1, 0, 1'b0, 1'b1, 8'h00);
        verify_ram(0, DEPTH - 1);

        // A1..A4 to 2..5, then read back at full rate
        do_write(2, 3, 0, 1'b0, 1'b0, 8'hA1);
        verify_ram(2, 3);
        check("a1_at_2", ram[2], 8'hA1);
        check("a4_at_5", ram[5], 8'hA4);
        do_read(2, 3, 0, 1'b0, -1);

        // Wrap past the top address
        do_write(14, 3, 0, 1'b0, 1'b0, 8'hB1);
        verify_ram(14, 3);
        check("wrap_15", ram[15], 8'hB2);
        check("wrap_0", ram[0], 8'hB3);
        check("wrap_1", ram[1], 8'hB4);

        // Gapped write data, then a stalled read on beat 2
        do_write(5, 3, 50, 1'b1, 1'b0, 8'hC1);
        do_read(14, 3, 0, 1'b0, 1);
        do_read(0, DEPTH - 1, 30, 1'b1, -1);

        // Randomized back-to-back bursts
        for (int k = 0; k < 12; k++) begin
            do_write($urandom_range(DEPTH - 1), $urandom_range(DEPTH - 1),
                     $urandom_range(60), 1'b1, 1'b1, 8'h00);
            do_read($urandom_range(DEPTH - 1), $urandom_range(DEPTH - 1),
                    $urandom_range(60), ($urandom_range(1) == 1), -1);
        end
        do_read(0, DEPTH - 1, 0, 1'b0, -1);

        // Reset in the middle of a write after two words have landed
        send_cmd(1'b1, 9, 5, 1'b0);
        bus.wd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.wd_data = DW'(8'hD0 + k);
            tick;
        end
        bus.wd_valid = 1'b0;
        exp_mem[9]   = 8'hD0;
        exp_mem[10]  = 8'hD1;
        check("pre_rst_wr_en", bus.ram_wr_en, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_wr_en", bus.ram_wr_en, 0);
        check("mid_rst_cmd_ready", bus.cmd_ready, 1);
        check("mid_rst_wd_ready", bus.wd_ready, 0);
        tick;
        check("mid_rst_done", bus.done, 0);
        tick;
        reset = 1'b1;
        check("post_rst_cmd_ready", bus.cmd_ready, 1);
        check("post_rst_w9", ram[9], 8'hD0);
        check("post_rst_w10", ram[10], 8'hD1);
        check("post_rst_w11", ram[11], exp_mem[11]);
        do_read(9, 2, 0, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
